uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter among NUM_REQ byte-stream requesters (e.g. feature dump, result reporter, debug).
//  Round-robin arbitration at packet granularity: a granted requester owns the TX until its byte flagged LAST is sent.
//  Sequences the UART TX handshake (DATA_IN/DATA_SEND/BUSY) byte by byte, with an acknowledge watchdog.
//  Sits between the requesters and the UART wrapper's TX side.
// PARAMETERS
//  NUM_REQ      4     number of requesters, 2..8
//  ACK_TIMEOUT  64    CLK cycles to wait for UART_BUSY to rise after a DATA_SEND pulse, >=2
// PORTS
//  CLK             in   1          system clock
//  RST             in   1          synchronous reset, active-high
//  REQ_VLD         in   NUM_REQ    per-requester byte valid
//  REQ_DATA        in   8*NUM_REQ  requester i byte at [8i+7:8i]
//  REQ_LAST        in   NUM_REQ    byte is last of its packet
//  REQ_RDY         out  NUM_REQ    byte accepted (one-hot, 1-cycle pulse)
//  GRANT           out  NUM_REQ    one-hot owner of the TX, 0 when idle
//  UART_DATA_IN    out  8          byte to UART TX
//  UART_DATA_SEND  out  1          1-cycle send strobe to UART TX
//  UART_BUSY       in   1          UART TX busy
//  PKT_DONE        out  1          1-cycle pulse: last byte of a packet fully transmitted
//  TIMEOUT_ERR     out  1          1-cycle pulse: UART_BUSY failed to rise within ACK_TIMEOUT
// BEHAVIOUR
//  Reset: state IDLE; GRANT, REQ_RDY, UART_DATA_SEND, PKT_DONE, TIMEOUT_ERR = 0; UART_DATA_IN = 8'h00;
//   rr pointer = NUM_REQ-1 (requester 0 has first priority). Reset mid-packet: all of the above next edge, packet lost.
//  States: IDLE, LOAD, SEND, ACK, DRAIN.
//  IDLE: if any REQ_VLD, grant first set bit searching from ptr+1 upward with wrap; GRANT registered -> LOAD.
//  LOAD: REQ_RDY[g] = GRANT[g] & REQ_VLD[g] & ~UART_BUSY (combinational). On accept: latch REQ_DATA slice into
//   UART_DATA_IN, latch REQ_LAST -> SEND. If REQ_VLD[g] low, hold in LOAD (packet lock; other requesters wait).
//  SEND: UART_DATA_SEND = 1 for exactly this cycle, UART_DATA_IN stable -> ACK; watchdog cleared.
//  ACK: wait UART_BUSY = 1 -> DRAIN. Watchdog counts cycles in ACK; at count ACK_TIMEOUT-1 without BUSY:
//   pulse TIMEOUT_ERR, abort packet: GRANT <= 0, ptr <= g, -> IDLE (no PKT_DONE; remaining bytes form a new packet).
//  DRAIN: wait UART_BUSY = 0. Then if latched LAST: pulse PKT_DONE, GRANT <= 0, ptr <= g -> IDLE; else -> LOAD.
//  UART_DATA_IN holds its last value outside SEND; only updated on accept.
//  Latency: REQ_VLD rise in IDLE at cycle 0 -> GRANT at 1, REQ_RDY at 1 (BUSY low), DATA_SEND at 2.
//  Packet switch: PKT_DONE cycle is in DRAIN; new GRANT earliest 2 cycles later (IDLE, then grant).
//  Simultaneous REQ_VLD: only round-robin winner granted; losers' REQ_RDY stay 0, data must be held by requester.
//  REQ_LAST on a single-byte packet: one byte, then PKT_DONE. Requester dropping VLD mid-packet is legal (stall).
//  GRANT never changes while state != IDLE; exactly one bit set outside IDLE.
// TESTING
//  T1 req0 sends 3 bytes 0x11,0x22,0x33 (LAST on 0x33), UART model BUSY 1 cycle after SEND for 20 cycles
//     -> DATA_SEND x3 with DATA_IN 0x11,0x22,0x33 in order, REQ_RDY[0] x3, one PKT_DONE, GRANT 4'b0001 throughout.
//  T2 all 4 requesters VLD from reset, 1-byte packets 0xA0..0xA3 -> grant order 0,1,2,3,0; bytes out A0,A1,A2,A3.
//  T3 req2 mid 4-byte packet, req1 raises VLD -> req1 waits; req1 granted only after req2 PKT_DONE.
//  T4 UART_BUSY tied 0 -> TIMEOUT_ERR pulses exactly ACK_TIMEOUT cycles after SEND; GRANT -> 0; next req granted.
//  T5 req0 drops VLD for 10 cycles mid-packet -> no DATA_SEND during gap, GRANT held, resumes with next byte.
//  T6 RST asserted while in ACK -> next cycle GRANT=0, DATA_SEND=0, IDLE; after release req0 granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART transmitter among NUM_REQ byte streams.
// Sequences the DATA_IN/DATA_SEND/BUSY handshake per byte with an acknowledge watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   REQ_VLD,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]   REQ_LAST,
  output logic [NUM_REQ-1:0]   REQ_RDY,
  output logic [NUM_REQ-1:0]   GRANT,
  output logic [7:0]           UART_DATA_IN,
  output logic                 UART_DATA_SEND,
  input  logic                 UART_BUSY,
  output logic                 PKT_DONE,
  output logic                 TIMEOUT_ERR
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned WdW  = $clog2(ACK_TIMEOUT);
  localparam logic [WdW-1:0] WdMax = WdW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSend, StAck, StDrain} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IdxW-1:0]    gidx_q;
  logic [IdxW-1:0]    ptr_q;
  logic [7:0]         data_q;
  logic               last_q;
  logic [WdW-1:0]     wdog_q;
  logic               send_q;

  logic [IdxW-1:0]    win_idx;
  logic               win_vld;
  logic [IdxW-1:0]    cand_idx;
  logic               accept;
  logic [7:0]         sel_data;
  logic               sel_last;

  // First requesting index strictly after the pointer, wrapping around.
  always_comb begin
    win_idx  = '0;
    win_vld  = 1'b0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IdxW'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_vld && REQ_VLD[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  assign REQ_RDY  = (state_q == StLoad && !UART_BUSY) ? (grant_q & REQ_VLD) : '0;
  assign accept   = |REQ_RDY;
  assign sel_data = REQ_DATA[32'(gidx_q) * 8 +: 8];
  assign sel_last = REQ_LAST[gidx_q];

  assign GRANT          = grant_q;
  assign UART_DATA_IN   = data_q;
  assign UART_DATA_SEND = send_q;
  assign PKT_DONE       = (state_q == StDrain) && !UART_BUSY && last_q;
  assign TIMEOUT_ERR    = (state_q == StAck) && !UART_BUSY && (wdog_q == WdMax);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= IdxW'(NUM_REQ - 1);
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      wdog_q  <= '0;
      send_q  <= 1'b0;
    end else begin
      send_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (win_vld) begin
            grant_q          <= '0;
            grant_q[win_idx] <= 1'b1;
            gidx_q           <= win_idx;
            state_q          <= StLoad;
          end
        end
        StLoad: begin
          // Packet lock: an idle owner stalls here and everyone else waits.
          if (accept) begin
            data_q  <= sel_data;
            last_q  <= sel_last;
            send_q  <= 1'b1;
            state_q <= StSend;
          end
        end
        StSend: begin
          wdog_q  <= '0;
          state_q <= StAck;
        end
        StAck: begin
          if (UART_BUSY) begin
            state_q <= StDrain;
          end else if (wdog_q == WdMax) begin
            // Abort; the owner's remaining bytes compete again as a new packet.
            grant_q <= '0;
            ptr_q   <= gidx_q;
            state_q <= StIdle;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StDrain: begin
          if (!UART_BUSY) begin
            if (last_q) begin
              grant_q <= '0;
              ptr_q   <= gidx_q;
              state_q <= StIdle;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
